mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the Fetch stage (instruction reads) and the Memory stage (data loads/stores).
- Sequences each access as a request/ready transaction on the memory port.
- Gives data accesses priority over fetch and stalls Fetch while a data access is pending or in flight.
- Sits between the pipeline stages and the memory model; pairs with the Execute stage's stall signal on load/store.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared single-ported memory arbiter.
// slave is the arbiter's view; master is the view of the stages and the memory model.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_done;
  logic [31:0] dm_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_error;

  modport slave (
    input  if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ready, mem_rdata,
    output if_done, if_rdata, if_stall, dm_done, dm_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, bus_error
  );

  modport master (
    output if_req, if_addr, dm_read, dm_write, dm_addr, dm_wdata, mem_ready, mem_rdata,
    input  if_done, if_rdata, if_stall, dm_done, dm_rdata,
           mem_addr, mem_wdata, mem_read, mem_write, bus_error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access, data first,
// with a bounded wait for mem_ready that aborts with bus_error.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_port_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t     state_r;
  logic [7:0] cnt_r;
  logic [7:0] cnt_inc_s;
  logic       dm_req_s;
  logic       expire_s;

  // Request decode and wait-limit detection for the access in flight.
  always_comb begin
    dm_req_s  = 1'b0;
    cnt_inc_s = 8'd0;
    expire_s  = 1'b0;
    dm_req_s  = bus.dm_read | bus.dm_write;
    cnt_inc_s = cnt_r + 8'd1;
    if (cnt_inc_s == TIMEOUT_C) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= 8'd0;
      bus.if_done   <= 1'b0;
      bus.if_rdata  <= 32'd0;
      bus.if_stall  <= 1'b0;
      bus.dm_done   <= 1'b0;
      bus.dm_rdata  <= 32'd0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.bus_error <= 1'b0;
    end else begin
      bus.if_done   <= 1'b0;
      bus.dm_done   <= 1'b0;
      bus.bus_error <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= 8'd0;
          if (dm_req_s) begin
            state_r       <= DM_BUSY;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            bus.mem_read  <= bus.dm_read;
            bus.mem_write <= bus.dm_write & ~bus.dm_read;
            bus.if_stall  <= 1'b1;
          end else if (bus.if_req) begin
            state_r       <= IF_BUSY;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= 32'd0;
            bus.mem_read  <= 1'b1;
            bus.mem_write <= 1'b0;
            bus.if_stall  <= 1'b1;
          end else begin
            bus.if_stall  <= 1'b0;
          end
        end
        DM_BUSY: begin
          if (bus.mem_ready) begin
            if (bus.mem_read) begin
              bus.dm_rdata <= bus.mem_rdata;
            end
            bus.dm_done   <= 1'b1;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.if_stall  <= 1'b0;
            cnt_r         <= 8'd0;
            state_r       <= IDLE;
          end else if (expire_s) begin
            bus.dm_rdata  <= 32'd0;
            bus.dm_done   <= 1'b1;
            bus.bus_error <= 1'b1;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.if_stall  <= 1'b0;
            cnt_r         <= 8'd0;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        IF_BUSY: begin
          // An expired wait still completes the fetch, with a zero instruction word.
          if (bus.mem_ready || expire_s) begin
            bus.if_rdata  <= bus.mem_ready ? bus.mem_rdata : 32'd0;
            bus.bus_error <= ~bus.mem_ready;
            bus.if_done   <= 1'b1;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.if_stall  <= 1'b0;
            cnt_r         <= 8'd0;
            state_r       <= IDLE;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r       <= IDLE;
          cnt_r         <= 8'd0;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b0;
          bus.if_stall  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: fetch, contention, store, timeout,
// reset mid-access and address stability, each against hand-computed values.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".mem_read"},  32'(bus.mem_read),  32'd0);
    check_eq({tag, ".mem_write"}, 32'(bus.mem_write), 32'd0);
    check_eq({tag, ".if_done"},   32'(bus.if_done),   32'd0);
    check_eq({tag, ".dm_done"},   32'(bus.dm_done),   32'd0);
    check_eq({tag, ".bus_error"}, 32'(bus.bus_error), 32'd0);
    check_eq({tag, ".if_stall"},  32'(bus.if_stall),  32'd0);
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'd0;
    bus.dm_read   = 1'b0;
    bus.dm_write  = 1'b0;
    bus.dm_addr   = 32'd0;
    bus.dm_wdata  = 32'd0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'd0;

    #1;
    check_idle_outputs("reset");
    check_eq("reset.mem_addr", bus.mem_addr, 32'd0);
    check_eq("reset.if_rdata", bus.if_rdata, 32'd0);
    step();
    reset = 1'b1;
    step();
    check_idle_outputs("post_reset");

    // Fetch only: two cycles of mem_read, then one if_done.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0040_0000;
    step();
    check_eq("fetch.mem_read0", 32'(bus.mem_read), 32'd1);
    check_eq("fetch.mem_addr",  bus.mem_addr, 32'h0040_0000);
    check_eq("fetch.if_stall",  32'(bus.if_stall), 32'd1);
    step();
    check_eq("fetch.mem_read1", 32'(bus.mem_read), 32'd1);
    check_eq("fetch.if_done_early", 32'(bus.if_done), 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h8C22_0004;
    step();
    check_eq("fetch.if_done",  32'(bus.if_done), 32'd1);
    check_eq("fetch.if_rdata", bus.if_rdata, 32'h8C22_0004);
    check_eq("fetch.mem_read_drop", 32'(bus.mem_read), 32'd0);
    check_eq("fetch.dm_done",  32'(bus.dm_done), 32'd0);
    check_eq("fetch.if_stall_drop", 32'(bus.if_stall), 32'd0);
    bus.if_req = 1'b0;
    step();
    check_idle_outputs("fetch.after");

    // mem_ready while idle must not produce any completion.
    step();
    check_idle_outputs("idle_ready");
    bus.mem_ready = 1'b0;

    // Contention: data wins, fetch follows after one idle cycle.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0040_0004;
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h1001_0000;
    step();
    check_eq("cont.mem_addr_dm", bus.mem_addr, 32'h1001_0000);
    check_eq("cont.mem_read",    32'(bus.mem_read), 32'd1);
    check_eq("cont.mem_write",   32'(bus.mem_write), 32'd0);
    check_eq("cont.if_stall",    32'(bus.if_stall), 32'd1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    step();
    check_eq("cont.dm_done",  32'(bus.dm_done), 32'd1);
    check_eq("cont.dm_rdata", bus.dm_rdata, 32'h1111_2222);
    check_eq("cont.if_done",  32'(bus.if_done), 32'd0);
    check_eq("cont.gap_read", 32'(bus.mem_read), 32'd0);
    bus.dm_read   = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    check_eq("cont.if_issue",   32'(bus.mem_read), 32'd1);
    check_eq("cont.if_addr",    bus.mem_addr, 32'h0040_0004);
    check_eq("cont.if_stall2",  32'(bus.if_stall), 32'd1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h2222_3333;
    step();
    check_eq("cont.if_done",  32'(bus.if_done), 32'd1);
    check_eq("cont.if_rdata", bus.if_rdata, 32'h2222_3333);
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    check_idle_outputs("cont.after");

    // Store: one cycle of mem_write, dm_rdata untouched.
    bus.dm_write = 1'b1;
    bus.dm_addr  = 32'h1001_0008;
    bus.dm_wdata = 32'hDEAD_BEEF;
    step();
    check_eq("store.mem_write", 32'(bus.mem_write), 32'd1);
    check_eq("store.mem_read",  32'(bus.mem_read), 32'd0);
    check_eq("store.mem_addr",  bus.mem_addr, 32'h1001_0008);
    check_eq("store.mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    check_eq("store.dm_done",    32'(bus.dm_done), 32'd1);
    check_eq("store.write_drop", 32'(bus.mem_write), 32'd0);
    check_eq("store.dm_rdata",   bus.dm_rdata, 32'h1111_2222);
    bus.dm_write  = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    check_idle_outputs("store.after");

    // Timeout with a fetch waiting behind the stalled load.
    bus.dm_read = 1'b1;
    bus.dm_addr = 32'h1001_0010;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0040_0008;
    step();
    check_eq("tmo.mem_read_start", 32'(bus.mem_read), 32'd1);
    for (int i = 1; i < 15; i++) begin
      step();
      check_eq("tmo.mem_read_hold", 32'(bus.mem_read), 32'd1);
      check_eq("tmo.no_error_yet",  32'(bus.bus_error), 32'd0);
    end
    step();
    check_eq("tmo.bus_error", 32'(bus.bus_error), 32'd1);
    check_eq("tmo.dm_done",   32'(bus.dm_done), 32'd1);
    check_eq("tmo.dm_rdata",  bus.dm_rdata, 32'd0);
    check_eq("tmo.read_drop", 32'(bus.mem_read), 32'd0);
    bus.dm_read = 1'b0;
    step();
    check_eq("tmo.err_pulse", 32'(bus.bus_error), 32'd0);
    check_eq("tmo.fetch_go",  32'(bus.mem_read), 32'd1);
    check_eq("tmo.fetch_addr", bus.mem_addr, 32'h0040_0008);

    // Reset while the fetch is in flight: outputs clear at once, no if_done.
    step();
    reset = 1'b0;
    #1;
    check_eq("rst.mem_read", 32'(bus.mem_read), 32'd0);
    check_eq("rst.mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst.if_rdata", bus.if_rdata, 32'd0);
    check_eq("rst.if_stall", 32'(bus.if_stall), 32'd0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    step();
    check_eq("rst.no_if_done", 32'(bus.if_done), 32'd0);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    step();
    check_eq("rst.reissue_read", 32'(bus.mem_read), 32'd1);
    check_eq("rst.reissue_addr", bus.mem_addr, 32'h0040_0008);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BAD_F00D;
    step();
    check_eq("rst.if_done",  32'(bus.if_done), 32'd1);
    check_eq("rst.if_rdata", bus.if_rdata, 32'h0BAD_F00D);
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    step();

    // Stability: inputs churn during a five-cycle access; read beats write.
    bus.dm_read  = 1'b1;
    bus.dm_write = 1'b1;
    bus.dm_addr  = 32'h1001_0020;
    bus.dm_wdata = 32'h1234_5678;
    step();
    check_eq("stab.mem_read",  32'(bus.mem_read), 32'd1);
    check_eq("stab.mem_write", 32'(bus.mem_write), 32'd0);
    for (int i = 1; i < 5; i++) begin
      bus.dm_addr  = 32'hA000_0000 + 32'(i);
      bus.dm_wdata = 32'h0F0F_0000 + 32'(i);
      bus.if_addr  = 32'hB000_0000 + 32'(i);
      bus.if_req   = 1'b1;
      step();
      check_eq("stab.mem_addr",  bus.mem_addr, 32'h1001_0020);
      check_eq("stab.mem_wdata", bus.mem_wdata, 32'h1234_5678);
      check_eq("stab.strobe",    32'(bus.mem_read), 32'd1);
    end
    bus.dm_addr   = 32'hC000_0000;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    check_eq("stab.dm_done",  32'(bus.dm_done), 32'd1);
    check_eq("stab.dm_rdata", bus.dm_rdata, 32'hCAFE_F00D);
    bus.dm_read   = 1'b0;
    bus.dm_write  = 1'b0;
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    check_idle_outputs("stab.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
